// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scan controller: prescaler, digit scan, hex decode,
// decimal points, leading-zero blanking, blink and PWM brightness. New values
// are captured on a load pulse and only become visible at a frame boundary.
module seg_scan_display #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 20000,
  parameter int BLINK_FRAMES = 256
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  input  logic [2:0]              brightness,
  output logic [NUM_DIGITS-1:0]   LEDSEL,
  output logic [7:0]              LEDOUT,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [31:0] SCAN_DIV_U = SCAN_DIV;

  // Scan position and the latched on-time threshold for the current slot
  logic [CNT_W-1:0]        cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [31:0]             thr_reg;

  // Pending (loaded) and shown (committed) display contents
  logic [4*NUM_DIGITS-1:0] pend_val_reg;
  logic [NUM_DIGITS-1:0]   pend_dp_reg;
  logic [4*NUM_DIGITS-1:0] shown_val_reg;
  logic [NUM_DIGITS-1:0]   shown_dp_reg;

  // Blink phase (1 = display visible) and frames elapsed in this phase
  logic                    blink_on_reg;
  logic [BLK_W-1:0]        blink_cnt_reg;

  logic                    slot_end;
  logic                    frame_wrap;
  logic [31:0]             thr_next;
  logic [NUM_DIGITS:1]     zero_above;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    digit_on;
  logic [6:0]              seg_next;
  logic [NUM_DIGITS-1:0]   ledsel_next;
  logic [7:0]              ledout_next;

  // Active-high segment pattern {g,f,e,d,c,b,a}; b and d use lowercase glyphs
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  assign slot_end   = (cnt_reg == CNT_W'(SCAN_DIV - 1));
  assign frame_wrap = slot_end && (idx_reg == IDX_W'(NUM_DIGITS - 1));

  // On-time threshold: lit for cnt in [1, thr], so brightness 7 gives SCAN_DIV-1 cycles
  assign thr_next = ((32'(brightness) + 32'd1) * SCAN_DIV_U) / 32'd8 - 32'd1;

  // zero_above[k] is set when nibbles k..NUM_DIGITS-1 of the shown value are all zero
  assign zero_above[NUM_DIGITS] = 1'b1;
  assign blank_mask[0] = 1'b0;   // the least significant digit always shows
  generate
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
      assign zero_above[gi] = zero_above[gi+1] && (shown_val_reg[4*gi +: 4] == 4'h0);
      assign blank_mask[gi] = blank_lz && zero_above[gi];
    end
  endgenerate

  assign cur_nib   = shown_val_reg[{idx_reg, 2'b00} +: 4];
  assign cur_dp    = shown_dp_reg[idx_reg];
  assign cur_blank = blank_mask[idx_reg];

  // cnt==0 is a guard cycle between digits so adjacent digits never overlap or ghost
  assign digit_on = (cnt_reg != '0) && (32'(cnt_reg) <= thr_reg) &&
                    !(blink_en && !blink_on_reg);

  assign seg_next    = cur_blank ? 7'h7F : ~hex_to_seg(cur_nib);
  assign ledsel_next = digit_on ? ~(NUM_DIGITS'(1) << idx_reg) : '1;
  assign ledout_next = digit_on ? {~cur_dp, seg_next} : 8'hFF;

  // Prescaler, digit index, and per-slot brightness sample taken in the guard cycle
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
      idx_reg <= '0;
      thr_reg <= '0;
    end else begin
      if (cnt_reg == '0)
        thr_reg <= thr_next;
      if (slot_end) begin
        cnt_reg <= '0;
        idx_reg <= (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  // Load into pending; commit at frame wrap, taking a same-cycle load directly
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      pend_val_reg  <= '0;
      pend_dp_reg   <= '0;
      shown_val_reg <= '0;
      shown_dp_reg  <= '0;
    end else begin
      if (load) begin
        pend_val_reg <= value;
        pend_dp_reg  <= dp_in;
      end
      if (frame_wrap) begin
        shown_val_reg <= load ? value : pend_val_reg;
        shown_dp_reg  <= load ? dp_in : pend_dp_reg;
      end
    end
  end

  // Blink phase: toggles every BLINK_FRAMES frames, held visible while blink is off
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      blink_on_reg  <= 1'b1;
      blink_cnt_reg <= '0;
    end else if (!blink_en) begin
      blink_on_reg  <= 1'b1;
      blink_cnt_reg <= '0;
    end else if (frame_wrap) begin
      if (blink_cnt_reg == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_reg <= '0;
        blink_on_reg  <= ~blink_on_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BLK_W'(1);
      end
    end
  end

  // Registered pin drivers and frame pulse
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      LEDSEL     <= '1;
      LEDOUT     <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      LEDSEL     <= ledsel_next;
      LEDOUT     <= ledout_next;
      frame_done <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display (4 digits, 16-cycle slots, 2-frame blink).
// A behavioural model queues the expected pin state every clock; a monitor
// pops and compares each cycle. Scenario tasks add targeted checks.
module tb_seg_scan_display;

  localparam int ND = 4;
  localparam int SD = 16;
  localparam int BF = 2;

  logic          Clk = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp_in = '0;
  logic          blank_lz = 1'b0;
  logic          blink_en = 1'b0;
  logic [2:0]    brightness = 3'd7;
  logic [3:0]    LEDSEL;
  logic [7:0]    LEDOUT;
  logic          frame_done;

  int checks = 0;
  int failures = 0;

  seg_scan_display #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .Clk(Clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .blink_en(blink_en), .brightness(brightness),
    .LEDSEL(LEDSEL), .LEDOUT(LEDOUT), .frame_done(frame_done)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] out;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];

  // Active-high glyphs {g..a} for 0-F
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state
  int          m_cnt, m_idx, m_thr, m_bcnt;
  logic [15:0] m_pend, m_shown;
  logic [3:0]  m_pdp, m_sdp;
  logic        m_on, m_lit, m_blank, m_wrap;
  logic [3:0]  m_nib;
  exp_t        m_e;

  // Model: on each clock, queue the pins the DUT should present, then advance
  initial begin
    forever begin
      @(posedge Clk or posedge reset);
      if (reset) begin
        m_cnt = 0; m_idx = 0; m_thr = 0; m_bcnt = 0;
        m_pend = '0; m_shown = '0; m_pdp = '0; m_sdp = '0; m_on = 1'b1;
        exp_q.delete();
      end else begin
        m_wrap  = (m_cnt == SD - 1) && (m_idx == ND - 1);
        m_lit   = (m_cnt > 0) && (m_cnt <= m_thr) && (!blink_en || m_on);
        m_nib   = 4'(m_shown >> (4 * m_idx));
        m_blank = blank_lz && (m_idx > 0) && ((m_shown >> (4 * m_idx)) == 16'h0);
        m_e.sel = 4'hF;
        m_e.out = 8'hFF;
        if (m_lit) begin
          m_e.sel[m_idx] = 1'b0;
          m_e.out = {~m_sdp[m_idx], m_blank ? 7'h7F : ~seg_tab[m_nib]};
        end
        m_e.fd = m_wrap;
        exp_q.push_back(m_e);
        if (m_cnt == 0) m_thr = ((int'(brightness) + 1) * SD) / 8 - 1;
        if (load) begin m_pend = value; m_pdp = dp_in; end
        if (m_wrap) begin m_shown = m_pend; m_sdp = m_pdp; end
        if (!blink_en) begin
          m_bcnt = 0; m_on = 1'b1;
        end else if (m_wrap) begin
          m_bcnt++;
          if (m_bcnt == BF) begin m_bcnt = 0; m_on = !m_on; end
        end
        m_cnt++;
        if (m_cnt == SD) begin m_cnt = 0; m_idx = (m_idx + 1) % ND; end
      end
    end
  end

  exp_t q_e;
  logic prev_fd = 1'b0;

  // Monitor: scoreboard compare plus one-hot and pulse-width properties every cycle
  initial begin
    forever begin
      @(negedge Clk);
      if (reset) begin
        checks++;
        if (LEDSEL !== 4'hF || LEDOUT !== 8'hFF || frame_done !== 1'b0) begin
          failures++;
          $display("FAIL sb_reset_state got sel=%h out=%h fd=%b required sel=f out=ff fd=0",
                   LEDSEL, LEDOUT, frame_done);
        end
      end else if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_empty got no expected entry at t=%0t required one per clock", $time);
      end else begin
        q_e = exp_q.pop_front();
        checks++;
        if (LEDSEL !== q_e.sel || LEDOUT !== q_e.out || frame_done !== q_e.fd) begin
          failures++;
          $display("FAIL sb_pins t=%0t got sel=%h out=%h fd=%b required sel=%h out=%h fd=%b",
                   $time, LEDSEL, LEDOUT, frame_done, q_e.sel, q_e.out, q_e.fd);
        end
      end
      checks++;
      if ($countones(~LEDSEL) > 1) begin
        failures++;
        $display("FAIL one_hot_sel got sel=%b required at most one low bit", LEDSEL);
      end
      checks++;
      if (frame_done === 1'b1 && prev_fd === 1'b1) begin
        failures++;
        $display("FAIL fd_width got frame_done high 2 cycles required 1-cycle pulse");
      end
      prev_fd = frame_done;
    end
  end

  task automatic wait_frame(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (frame_done !== 1'b1 && n < budget);
    if (frame_done !== 1'b1) begin
      checks++; failures++;
      $display("FAIL wait_frame got no frame_done in %0d cycles required a pulse", n);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if (LEDSEL !== 4'hF || LEDOUT !== 8'hFF || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold got sel=%h out=%h fd=%b required f/ff/0", LEDSEL, LEDOUT, frame_done);
    end
    reset = 1'b0;
    @(negedge Clk);
    checks++;
    if (LEDSEL !== 4'hF) begin
      failures++;
      $display("FAIL reset_guard got sel=%h required f", LEDSEL);
    end
    @(negedge Clk);
    checks++;
    if (LEDSEL !== 4'hE || LEDOUT !== 8'hC0) begin
      failures++;
      $display("FAIL reset_first_lit got sel=%h out=%h required e/c0", LEDSEL, LEDOUT);
    end
    // pending load mid-frame, then reset must discard it
    repeat (18) @(negedge Clk);
    value = 16'h9999; dp_in = 4'hF; load = 1'b1;
    @(negedge Clk);
    load = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if (LEDSEL !== 4'hD) begin
      failures++;
      $display("FAIL reset_pre_lit got sel=%h required d", LEDSEL);
    end
    @(posedge Clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (LEDSEL !== 4'hF || LEDOUT !== 8'hFF || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_async got sel=%h out=%h fd=%b required f/ff/0", LEDSEL, LEDOUT, frame_done);
    end
    @(negedge Clk);
    reset = 1'b0;
    value = '0; dp_in = '0;
    wait_frame(100);
    repeat (2) @(negedge Clk);
    checks++;
    if (LEDSEL !== 4'hE || LEDOUT !== 8'hC0) begin
      failures++;
      $display("FAIL reset_discard got sel=%h out=%h required e/c0", LEDSEL, LEDOUT);
    end
  endtask

  task automatic test_load();
    int n;
    wait_frame(100);
    repeat (5) @(negedge Clk);
    value = 16'h3333; dp_in = 4'h0; load = 1'b1;
    @(negedge Clk);
    load = 1'b0;
    repeat (4) @(negedge Clk);
    value = 16'h12AF; dp_in = 4'b0100; load = 1'b1;
    @(negedge Clk);
    load = 1'b0; value = 16'hEEEE; dp_in = 4'hF;
    repeat (23) @(negedge Clk);
    checks++;
    if (LEDSEL !== 4'hB || LEDOUT !== 8'hC0) begin
      failures++;
      $display("FAIL load_old got sel=%h out=%h required b/c0", LEDSEL, LEDOUT);
    end
    wait_frame(100);
    repeat (2) @(negedge Clk);
    checks++;
    if (LEDSEL !== 4'hE || LEDOUT !== 8'h8E) begin
      failures++;
      $display("FAIL load_d0 got sel=%h out=%h required e/8e", LEDSEL, LEDOUT);
    end
    repeat (16) @(negedge Clk);
    checks++;
    if (LEDSEL !== 4'hD || LEDOUT !== 8'h88) begin
      failures++;
      $display("FAIL load_d1 got sel=%h out=%h required d/88", LEDSEL, LEDOUT);
    end
    repeat (16) @(negedge Clk);
    checks++;
    if (LEDSEL !== 4'hB || LEDOUT !== 8'h24) begin
      failures++;
      $display("FAIL load_d2_dp got sel=%h out=%h required b/24", LEDSEL, LEDOUT);
    end
    repeat (16) @(negedge Clk);
    checks++;
    if (LEDSEL !== 4'h7 || LEDOUT !== 8'hF9) begin
      failures++;
      $display("FAIL load_d3 got sel=%h out=%h required 7/f9", LEDSEL, LEDOUT);
    end
    wait_frame(100);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (frame_done !== 1'b1 && n < 200);
    checks++;
    if (n != ND * SD) begin
      failures++;
      $display("FAIL frame_period got %0d cycles required %0d", n, ND * SD);
    end
  endtask

  task automatic test_blank();
    repeat (3) @(negedge Clk);
    blank_lz = 1'b1; value = 16'h0030; dp_in = 4'h0; load = 1'b1;
    @(negedge Clk);
    load = 1'b0;
    wait_frame(100);
    repeat (2) @(negedge Clk);
    checks++;
    if (LEDSEL !== 4'hE || LEDOUT !== 8'hC0) begin
      failures++;
      $display("FAIL blank_d0 got sel=%h out=%h required e/c0", LEDSEL, LEDOUT);
    end
    repeat (16) @(negedge Clk);
    checks++;
    if (LEDSEL !== 4'hD || LEDOUT !== 8'hB0) begin
      failures++;
      $display("FAIL blank_d1 got sel=%h out=%h required d/b0", LEDSEL, LEDOUT);
    end
    repeat (16) @(negedge Clk);
    checks++;
    if (LEDSEL !== 4'hB || LEDOUT !== 8'hFF) begin
      failures++;
      $display("FAIL blank_d2 got sel=%h out=%h required b/ff", LEDSEL, LEDOUT);
    end
    repeat (16) @(negedge Clk);
    checks++;
    if (LEDSEL !== 4'h7 || LEDOUT !== 8'hFF) begin
      failures++;
      $display("FAIL blank_d3 got sel=%h out=%h required 7/ff", LEDSEL, LEDOUT);
    end
    @(negedge Clk);
    value = 16'h0000; dp_in = 4'b0010; load = 1'b1;
    @(negedge Clk);
    load = 1'b0;
    wait_frame(100);
    repeat (2) @(negedge Clk);
    checks++;
    if (LEDSEL !== 4'hE || LEDOUT !== 8'hC0) begin
      failures++;
      $display("FAIL blank_zero_d0 got sel=%h out=%h required e/c0", LEDSEL, LEDOUT);
    end
    repeat (16) @(negedge Clk);
    checks++;
    if (LEDSEL !== 4'hD || LEDOUT !== 8'h7F) begin
      failures++;
      $display("FAIL blank_zero_dp got sel=%h out=%h required d/7f", LEDSEL, LEDOUT);
    end
    repeat (16) @(negedge Clk);
    checks++;
    if (LEDSEL !== 4'hB || LEDOUT !== 8'hFF) begin
      failures++;
      $display("FAIL blank_zero_d2 got sel=%h out=%h required b/ff", LEDSEL, LEDOUT);
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_brightness();
    int lows;
    wait_frame(100);
    brightness = 3'd0;
    lows = 0;
    for (int i = 0; i < SD; i++) begin
      @(negedge Clk);
      if (LEDSEL[0] === 1'b0) lows++;
    end
    checks++;
    if (lows != 1) begin
      failures++;
      $display("FAIL bright0_d0 got %0d lit cycles required 1", lows);
    end
    lows = 0;
    for (int i = 0; i < SD; i++) begin
      @(negedge Clk);
      if (LEDSEL[1] === 1'b0) lows++;
    end
    checks++;
    if (lows != 1) begin
      failures++;
      $display("FAIL bright0_d1 got %0d lit cycles required 1", lows);
    end
    brightness = 3'd7;
    lows = 0;
    for (int i = 0; i < SD; i++) begin
      @(negedge Clk);
      if (LEDSEL[2] === 1'b0) lows++;
    end
    checks++;
    if (lows != 15) begin
      failures++;
      $display("FAIL bright7_d2 got %0d lit cycles required 15", lows);
    end
    lows = 0;
    for (int i = 1; i <= SD; i++) begin
      @(negedge Clk);
      if (i == 5) brightness = 3'd0;
      if (LEDSEL[3] === 1'b0) lows++;
    end
    checks++;
    if (lows != 15) begin
      failures++;
      $display("FAIL bright_midslot got %0d lit cycles required 15", lows);
    end
    lows = 0;
    for (int i = 0; i < SD; i++) begin
      @(negedge Clk);
      if (LEDSEL[0] === 1'b0) lows++;
    end
    checks++;
    if (lows != 1) begin
      failures++;
      $display("FAIL bright_nextslot got %0d lit cycles required 1", lows);
    end
    brightness = 3'd7;
  endtask

  task automatic test_blink();
    int lit, n, want;
    wait_frame(100);
    blink_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      lit = 0; n = 0;
      do begin
        @(negedge Clk);
        n++;
        if (LEDSEL !== 4'hF) lit++;
      end while (frame_done !== 1'b1 && n < 200);
      want = ((f / BF) % 2 == 0) ? ND * (SD - 1) : 0;
      checks++;
      if (lit != want) begin
        failures++;
        $display("FAIL blink_frame%0d got %0d lit cycles required %0d", f, lit, want);
      end
    end
    blink_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    repeat (ND * SD - 1) @(negedge Clk);
    value = 16'h5678; dp_in = 4'b0001; load = 1'b1;
    @(negedge Clk);
    load = 1'b0; value = '0; dp_in = '0;
    checks++;
    if (frame_done !== 1'b1) begin
      failures++;
      $display("FAIL bypass_align got fd=%b required 1", frame_done);
    end
    repeat (2) @(negedge Clk);
    checks++;
    if (LEDSEL !== 4'hE || LEDOUT !== 8'h00) begin
      failures++;
      $display("FAIL bypass_d0 got sel=%h out=%h required e/00", LEDSEL, LEDOUT);
    end
    repeat (16) @(negedge Clk);
    checks++;
    if (LEDSEL !== 4'hD || LEDOUT !== 8'hF8) begin
      failures++;
      $display("FAIL bypass_d1 got sel=%h out=%h required d/f8", LEDSEL, LEDOUT);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_blank();
    test_brightness();
    test_blink();
    test_back_to_back();
    repeat (2) @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got no completion by %0t required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
